// File: rtl/dram_ctrl_pkg.sv
// dram_ctrl_pkg: shared state encoding and geometry of the byte DRAM lane arbiter
package dram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam int LANES_PER_GROUP = 8;
  localparam int NUM_LANES = 16;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 8;
  localparam int DRAM_WAIT_CYCLES = 20;
endpackage

// File: rtl/dram_batch_select.sv
// dram_batch_select: picks the direction to serve and the batch of requesters pending in it
module dram_batch_select #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [NUM_REQ-1:0] req_rdwr,
  input  logic               dir_pri,
  output logic [NUM_REQ-1:0] batch,
  output logic               dir,
  output logic               toggle
);
  logic [NUM_REQ-1:0] rd, wr;
  always_comb begin
    rd = req_valid & req_rdwr;
    wr = req_valid & ~req_rdwr;
    toggle = |rd && |wr;
    dir = toggle ? ~dir_pri : |rd;
    batch = dir ? rd : wr;
  end
endmodule

// File: rtl/dram_lane_arbiter.sv
// dram_lane_arbiter: batches same-direction requests onto DRAM lane group 0, one transaction at a time
module dram_lane_arbiter
  import dram_ctrl_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WAIT_CYCLES = DRAM_WAIT_CYCLES,
  parameter int TIMEOUT     = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_rdwr,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            resp_valid,
  output logic [NUM_REQ*DATA_W-1:0]     resp_rdata,
  output logic                          resp_err,
  output logic                          busy,
  output logic [NUM_LANES-1:0]          dram_en,
  output logic [1:0]                    dram_rdwr,
  output logic [NUM_LANES*ADDR_W-1:0]   dram_addr,
  output logic [NUM_LANES*DATA_W-1:0]   dram_data_in,
  input  logic [NUM_LANES*DATA_W-1:0]   dram_data_out,
  input  logic [NUM_LANES-1:0]          dram_valid
);
  localparam int CNT_W = $clog2(WAIT_CYCLES + TIMEOUT + 1);
  state_t state;
  logic [NUM_REQ-1:0] sel, batch;
  logic sel_dir, toggle, dir, dir_pri, hit, done, unused_hi;
  logic [CNT_W-1:0] cnt;
  logic [NUM_REQ*ADDR_W-1:0] addr_q;
  logic [NUM_REQ*DATA_W-1:0] wdata_q;
  dram_batch_select #(.NUM_REQ(NUM_REQ)) u_sel (
    .req_valid(req_valid),
    .req_rdwr (req_rdwr),
    .dir_pri  (dir_pri),
    .batch    (sel),
    .dir      (sel_dir),
    .toggle   (toggle)
  );
  assign req_ready = state == IDLE ? sel : '0;
  assign busy = state != IDLE;
  assign dram_rdwr = {1'b0, dir};
  assign dram_addr = (NUM_LANES*ADDR_W)'(addr_q);
  assign dram_data_in = (NUM_LANES*DATA_W)'(wdata_q);
  assign hit = dir && |(dram_valid[NUM_REQ-1:0] & batch);
  // writes complete blindly after the fixed latency; reads get TIMEOUT extra cycles
  assign done = dir ? cnt == CNT_W'(WAIT_CYCLES + TIMEOUT) : cnt == CNT_W'(WAIT_CYCLES);
  assign unused_hi = ^{dram_valid[NUM_LANES-1:NUM_REQ], dram_data_out[NUM_LANES*DATA_W-1:NUM_REQ*DATA_W]};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      batch <= '0;
      dir <= 1'b0;
      dir_pri <= 1'b0;
      cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      dram_en <= '0;
      resp_valid <= '0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else begin
      dram_en <= '0;
      resp_valid <= '0;
      resp_err <= 1'b0;
      case (state)
        IDLE: if (|sel) begin
          state <= ISSUE;
          batch <= sel;
          dir <= sel_dir;
          dir_pri <= dir_pri ^ toggle;
          addr_q <= req_addr;
          wdata_q <= req_wdata;
          dram_en <= NUM_LANES'(sel);
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: if (hit) begin
          state <= RESP;
          resp_valid <= batch;
          for (int i = 0; i < NUM_REQ; i++)
            if (batch[i]) resp_rdata[i*DATA_W +: DATA_W] <= dram_data_out[i*DATA_W +: DATA_W];
        end else if (done) begin
          state <= RESP;
          resp_valid <= batch;
          resp_err <= dir;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_dram_lane_arbiter.sv
// tb_dram_lane_arbiter: directed tests of the lane arbiter against a fixed-latency byte DRAM model
module tb_dram_lane_arbiter;
  localparam int NR = 4;
  localparam int WC = 20;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NR-1:0] req_valid = '0, req_rdwr = '0, req_ready, resp_valid;
  logic [NR*64-1:0] req_addr = '0;
  logic [NR*8-1:0] req_wdata = '0, resp_rdata;
  logic resp_err, busy;
  logic [15:0] dram_en, dram_valid;
  logic [1:0] dram_rdwr;
  logic [1023:0] dram_addr;
  logic [127:0] dram_data_in, dram_data_out;
  int checks = 0, errors = 0;
  int en_busy_err = 0;
  bit stub = 0;
  int cd;
  logic [15:0] m_mask;
  logic m_rd;
  logic [7:0] m_addr [16];
  logic [7:0] m_wd [16];
  logic [7:0] mem [256];

  dram_lane_arbiter #(.NUM_REQ(NR), .WAIT_CYCLES(WC), .TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_rdwr(req_rdwr), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy), .dram_en(dram_en), .dram_rdwr(dram_rdwr), .dram_addr(dram_addr),
    .dram_data_in(dram_data_in), .dram_data_out(dram_data_out), .dram_valid(dram_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cd <= 0;
      dram_valid <= '0;
      dram_data_out <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h10] <= 8'hA5;
    end else begin
      dram_valid <= '0;
      if (dram_en != '0) begin
        if (cd != 0) en_busy_err <= en_busy_err + 1;
        cd <= WC;
        m_mask <= dram_en;
        m_rd <= dram_rdwr[0];
        for (int i = 0; i < 16; i++) begin
          m_addr[i] <= dram_addr[i*64 +: 8];
          m_wd[i] <= dram_data_in[i*8 +: 8];
        end
      end else if (cd != 0) begin
        cd <= cd - 1;
        if (cd == 1) begin
          for (int i = 0; i < 16; i++)
            if (m_mask[i]) begin
              if (m_rd) dram_data_out[i*8 +: 8] <= mem[m_addr[i]];
              else mem[m_addr[i]] <= m_wd[i];
            end
          if (m_rd && !stub) dram_valid <= m_mask;
        end
      end
    end

  task automatic do_reset;
    reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_resp(output int n, output bit en_seen);
    n = 1;
    en_seen = 0;
    while (resp_valid == '0 && n < 60) begin
      @(negedge clk);
      n++;
      if (dram_en != '0) en_seen = 1;
    end
  endtask

  task automatic test_reset;
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dram_en !== 16'h0) begin errors++; $display("FAIL reset_en: got %h want 0", dram_en); end
    checks++; if (resp_valid !== 4'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp: got %h/%b want 0/0", resp_valid, resp_err); end
    checks++; if (resp_rdata !== 32'h0 || req_ready !== 4'h0) begin errors++; $display("FAIL reset_rdata_ready: got %h/%h want 0/0", resp_rdata, req_ready); end
    checks++; if (dram_addr !== 1024'h0 || dram_data_in !== 128'h0 || dram_rdwr !== 2'b00) begin errors++; $display("FAIL reset_dram_bus: rdwr %b want 00, addr/data nonzero", dram_rdwr); end
  endtask

  task automatic test_single_read;
    int n; bit e;
    @(posedge clk); #1;
    req_addr[63:0] = 64'h10; req_rdwr = 4'b0001; req_valid = 4'b0001;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rd_ready: got %h want 1", req_ready); end
    checks++; if (dram_en !== 16'h0 || busy !== 1'b0) begin errors++; $display("FAIL rd_c0: en %h busy %b want 0/0", dram_en, busy); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    checks++; if (dram_en !== 16'h0001) begin errors++; $display("FAIL rd_en: got %h want 0001", dram_en); end
    checks++; if (dram_rdwr !== 2'b01 || dram_addr[63:0] !== 64'h10 || busy !== 1'b1) begin errors++; $display("FAIL rd_bus: rdwr %b addr %h busy %b want 01/10/1", dram_rdwr, dram_addr[63:0], busy); end
    wait_resp(n, e);
    checks++; if (n !== 23 || e) begin errors++; $display("FAIL rd_latency: got %0d en_extra %b want 23/0", n, e); end
    checks++; if (resp_valid !== 4'b0001 || resp_rdata[7:0] !== 8'hA5 || resp_err !== 1'b0) begin errors++; $display("FAIL rd_resp: got %h/%h/%b want 1/a5/0", resp_valid, resp_rdata[7:0], resp_err); end
    @(negedge clk);
    checks++; if (resp_valid !== 4'h0 || busy !== 1'b0 || resp_rdata[7:0] !== 8'hA5) begin errors++; $display("FAIL rd_after: got %h/%b/%h want 0/0/a5", resp_valid, busy, resp_rdata[7:0]); end
  endtask

  task automatic test_mixed;
    int n; bit e;
    do_reset();
    @(posedge clk); #1;
    req_addr = {64'h0, 64'h10, 64'h30, 64'h10};
    req_wdata = {8'h0, 8'h0, 8'h77, 8'h0};
    req_rdwr = 4'b0101; req_valid = 4'b0111;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL mix_first: got %h want 5", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0010;
    @(negedge clk);
    checks++; if (dram_en !== 16'h0005 || dram_rdwr !== 2'b01) begin errors++; $display("FAIL mix_en1: got %h/%b want 0005/01", dram_en, dram_rdwr); end
    wait_resp(n, e);
    checks++; if (n !== 23 || resp_valid !== 4'b0101 || resp_rdata[7:0] !== 8'hA5 || resp_rdata[23:16] !== 8'hA5) begin errors++; $display("FAIL mix_resp1: n %0d valid %h rdata %h want 23/5/xxa5xxa5", n, resp_valid, resp_rdata); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mix_second: got %h want 2", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    checks++; if (dram_en !== 16'h0002 || dram_rdwr !== 2'b00 || dram_data_in[15:8] !== 8'h77) begin errors++; $display("FAIL mix_en2: got %h/%b/%h want 0002/00/77", dram_en, dram_rdwr, dram_data_in[15:8]); end
    wait_resp(n, e);
    checks++; if (n !== 23 || resp_valid !== 4'b0010 || resp_err !== 1'b0) begin errors++; $display("FAIL mix_resp2: n %0d valid %h err %b want 23/2/0", n, resp_valid, resp_err); end
    @(posedge clk); #1; req_valid = 4'b0111;
    @(negedge clk);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mix_third_wr_first: got %h want 2", req_ready); end
    @(posedge clk); #1; req_valid = 4'b0101;
    @(negedge clk);
    wait_resp(n, e);
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL mix_resp3: got %h want 2", resp_valid); end
    @(negedge clk);
    checks++; if (req_ready !== 4'b0101) begin errors++; $display("FAIL mix_fourth: got %h want 5", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    wait_resp(n, e);
    checks++; if (resp_valid !== 4'b0101) begin errors++; $display("FAIL mix_resp4: got %h want 5", resp_valid); end
  endtask

  task automatic test_batched_writes;
    int n; bit e;
    @(posedge clk); #1;
    req_addr = {64'h3, 64'h2, 64'h1, 64'h0};
    req_wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req_rdwr = 4'b0000; req_valid = 4'b1111;
    @(negedge clk);
    checks++; if (req_ready !== 4'hF) begin errors++; $display("FAIL wr_ready: got %h want f", req_ready); end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    checks++; if (dram_en !== 16'h000F || dram_rdwr !== 2'b00) begin errors++; $display("FAIL wr_en: got %h/%b want 000f/00", dram_en, dram_rdwr); end
    checks++; if (dram_data_in[31:0] !== 32'h44332211 || dram_data_in[127:32] !== 96'h0 || dram_addr[1023:256] !== 768'h0) begin errors++; $display("FAIL wr_bus: data %h want 44332211, upper lanes 0", dram_data_in[31:0]); end
    wait_resp(n, e);
    checks++; if (n !== 23 || e || resp_valid !== 4'hF || resp_err !== 1'b0) begin errors++; $display("FAIL wr_resp: n %0d en_extra %b valid %h err %b want 23/0/f/0", n, e, resp_valid, resp_err); end
    @(posedge clk); #1; req_rdwr = 4'b1111; req_valid = 4'b1111;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    checks++; if (dram_en !== 16'h000F || dram_rdwr !== 2'b01) begin errors++; $display("FAIL wr_rdback_en: got %h/%b want 000f/01", dram_en, dram_rdwr); end
    wait_resp(n, e);
    checks++; if (n !== 23 || resp_valid !== 4'hF || resp_rdata !== 32'h44332211) begin errors++; $display("FAIL wr_rdback: n %0d valid %h rdata %h want 23/f/44332211", n, resp_valid, resp_rdata); end
  endtask

  task automatic test_same_addr;
    int n; bit e;
    @(posedge clk); #1;
    req_addr = {64'h0, 64'h0, 64'h20, 64'h20};
    req_wdata = {8'h0, 8'h0, 8'h66, 8'h55};
    req_rdwr = 4'b0000; req_valid = 4'b0011;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    wait_resp(n, e);
    @(posedge clk); #1;
    req_addr = {64'h0, 64'h20, 64'h0, 64'h0};
    req_rdwr = 4'b0100; req_valid = 4'b0100;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    wait_resp(n, e);
    checks++; if (resp_valid !== 4'b0100 || resp_rdata[23:16] !== 8'h66) begin errors++; $display("FAIL same_addr: valid %h rdata %h want 4/66", resp_valid, resp_rdata[23:16]); end
  endtask

  task automatic test_timeout;
    int n; bit e;
    stub = 1;
    @(posedge clk); #1;
    req_addr = {64'h10, 64'h0, 64'h0, 64'h0};
    req_rdwr = 4'b1000; req_valid = 4'b1000;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    wait_resp(n, e);
    checks++; if (n !== 31) begin errors++; $display("FAIL to_latency: got %0d want 31", n); end
    checks++; if (resp_valid !== 4'b1000 || resp_err !== 1'b1 || resp_rdata[31:24] !== 8'h44) begin errors++; $display("FAIL to_resp: valid %h err %b rdata %h want 8/1/44", resp_valid, resp_err, resp_rdata[31:24]); end
    @(negedge clk);
    checks++; if (resp_err !== 1'b0 || resp_valid !== 4'h0) begin errors++; $display("FAIL to_after: err %b valid %h want 0/0", resp_err, resp_valid); end
    stub = 0;
  endtask

  task automatic test_back_to_back;
    int na;
    int acc [4];
    na = 0;
    @(posedge clk); #1;
    req_addr = {64'h0, 64'h0, 64'h0, 64'h10};
    req_rdwr = 4'b0001; req_valid = 4'b0001;
    for (int c = 0; c < 72; c++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        if (na < 4) acc[na] = c;
        na++;
      end
    end
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    checks++; if (na !== 3) begin errors++; $display("FAIL b2b_count: got %0d want 3", na); end
    else begin
      checks++; if (acc[0] !== 0 || acc[1] !== 24 || acc[2] !== 48) begin errors++; $display("FAIL b2b_spacing: got %0d/%0d/%0d want 0/24/48", acc[0], acc[1], acc[2]); end
    end
    checks++; if (en_busy_err !== 0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_dram_busy: overlaps %0d busy %b want 0/0", en_busy_err, busy); end
  endtask

  task automatic test_reset_mid;
    int n; bit e; bit seen;
    @(posedge clk); #1;
    req_addr = {64'h0, 64'h0, 64'h10, 64'h10};
    req_rdwr = 4'b0011; req_valid = 4'b0001;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    repeat (9) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: busy %b want 1", busy); end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || dram_en !== 16'h0 || dram_rdwr !== 2'b00 || dram_addr !== 1024'h0) begin errors++; $display("FAIL rst_mid_bus: busy %b en %h rdwr %b want 0/0/00", busy, dram_en, dram_rdwr); end
    checks++; if (resp_valid !== 4'h0 || resp_rdata !== 32'h0 || req_ready !== 4'h0) begin errors++; $display("FAIL rst_mid_resp: valid %h rdata %h ready %h want 0/0/0", resp_valid, resp_rdata, req_ready); end
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid_noresp: got resp_valid after reset, want none"); end
    @(posedge clk); #1; req_valid = 4'b0010;
    @(negedge clk);
    @(posedge clk); #1; req_valid = '0;
    @(negedge clk);
    wait_resp(n, e);
    checks++; if (n !== 23 || resp_valid !== 4'b0010 || resp_rdata[15:8] !== 8'hA5) begin errors++; $display("FAIL rst_mid_after: n %0d valid %h rdata %h want 23/2/a5", n, resp_valid, resp_rdata[15:8]); end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_mixed();
    test_batched_writes();
    test_same_addr();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
